// File: rtl/alu_pkg.sv
// Shared widths, ALU function codes and the operand-stage entry format.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int FN_W  = 5;
    localparam int IDX_W = 5;

    localparam logic [FN_W-1:0] FN_AND = 5'h0;
    localparam logic [FN_W-1:0] FN_OR  = 5'h1;
    localparam logic [FN_W-1:0] FN_XOR = 5'h2;
    localparam logic [FN_W-1:0] FN_SLL = 5'h4;
    localparam logic [FN_W-1:0] FN_SRL = 5'h5;
    localparam logic [FN_W-1:0] FN_SRA = 5'h6;
    localparam logic [FN_W-1:0] FN_ADD = 5'h8;
    localparam logic [FN_W-1:0] FN_SUB = 5'h9;
    localparam logic [FN_W-1:0] FN_SLT = 5'hC;
    localparam logic [FN_W-1:0] FN_SLTU = 5'hD;

    typedef struct packed {
        logic [FN_W-1:0]  fn;
        logic [XLEN-1:0]  a;
        logic [XLEN-1:0]  b;
        logic [IDX_W-1:0] a_idx;
        logic [IDX_W-1:0] b_idx;
        logic             a_byp;
        logic             b_byp;
    } alu_op_t;

endpackage

// File: rtl/alu_operand_stage_if.sv
// Decode-side, bypass and ALU-side signals of the operand stage.
interface alu_operand_stage_if;
    import alu_pkg::*;

    logic             in_valid;
    logic             in_ready;
    logic [FN_W-1:0]  in_fn;
    logic [IDX_W-1:0] in_rs1_idx;
    logic [IDX_W-1:0] in_rs2_idx;
    logic [XLEN-1:0]  in_rs1_data;
    logic [XLEN-1:0]  in_rs2_data;
    logic [XLEN-1:0]  in_imm;
    logic [XLEN-1:0]  in_pc;
    logic             in_a_is_pc;
    logic             in_b_is_imm;
    logic             ex_byp_valid;
    logic [IDX_W-1:0] ex_byp_idx;
    logic [XLEN-1:0]  ex_byp_data;
    logic             wb_byp_valid;
    logic [IDX_W-1:0] wb_byp_idx;
    logic [XLEN-1:0]  wb_byp_data;
    logic             out_valid;
    logic             out_ready;
    logic [FN_W-1:0]  out_fn;
    logic [XLEN-1:0]  out_a;
    logic [XLEN-1:0]  out_b;

    modport slave (
        input  in_valid, in_fn, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
               in_imm, in_pc, in_a_is_pc, in_b_is_imm,
               ex_byp_valid, ex_byp_idx, ex_byp_data,
               wb_byp_valid, wb_byp_idx, wb_byp_data, out_ready,
        output in_ready, out_valid, out_fn, out_a, out_b
    );

    modport master (
        output in_valid, in_fn, in_rs1_idx, in_rs2_idx, in_rs1_data, in_rs2_data,
               in_imm, in_pc, in_a_is_pc, in_b_is_imm,
               ex_byp_valid, ex_byp_idx, ex_byp_data,
               wb_byp_valid, wb_byp_idx, wb_byp_data, out_ready,
        input  in_ready, out_valid, out_fn, out_a, out_b
    );

endinterface

// File: rtl/alu_byp_mux.sv
// One operand's EX/WB forwarding select; register index 0 always reads as zero.
module alu_byp_mux
    import alu_pkg::*;
(
    input  logic             src_is_reg,
    input  logic [IDX_W-1:0] idx,
    input  logic [XLEN-1:0]  cur_data,
    input  logic             ex_valid,
    input  logic [IDX_W-1:0] ex_idx,
    input  logic [XLEN-1:0]  ex_data,
    input  logic             wb_valid,
    input  logic [IDX_W-1:0] wb_idx,
    input  logic [XLEN-1:0]  wb_data,
    output logic [XLEN-1:0]  data_out,
    output logic             byp_out
);

    always_comb begin
        byp_out  = src_is_reg && (idx != '0);
        data_out = cur_data;
        if (src_is_reg && (idx == '0)) begin
            data_out = '0;
        end else if (byp_out && ex_valid && (ex_idx == idx)) begin
            data_out = ex_data;
        end else if (byp_out && wb_valid && (wb_idx == idx)) begin
            data_out = wb_data;
        end
    end

endmodule

// File: rtl/alu_operand_stage.sv
// ALU operand-select pipeline stage with a 2-entry skid buffer and live bypass.
// Optional stall counter enabled by defining ALU_OPSTAGE_PERF_EN.
module alu_operand_stage
    import alu_pkg::*;
(
    input  logic                 clock,
    input  logic                 reset,
    alu_operand_stage_if.slave   bus
`ifdef ALU_OPSTAGE_PERF_EN
    ,
    output logic [31:0]          stall_cnt
`endif
);

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_ONE   = 2'd1;
    localparam logic [1:0] ST_FULL  = 2'd2;

    logic [1:0] state_q, state_d;
    logic       in_ready_q, in_ready_d;
    alu_op_t    main_q, main_d, skid_q, skid_d;
    alu_op_t    cap_op, main_upd, skid_upd;
    logic       main_valid, in_fire, out_fire;

    assign main_valid = (state_q != ST_EMPTY);
    assign in_fire    = bus.in_valid && in_ready_q;
    assign out_fire   = main_valid && bus.out_ready;

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = main_valid;
    assign bus.out_fn    = main_q.fn;
    assign bus.out_a     = main_q.a;
    assign bus.out_b     = main_q.b;

    // Capture path: operand source select followed by same-cycle forwarding.
    assign cap_op.fn    = bus.in_fn;
    assign cap_op.a_idx = bus.in_rs1_idx;
    assign cap_op.b_idx = bus.in_rs2_idx;

    alu_byp_mux u_cap_a (
        .src_is_reg(!bus.in_a_is_pc), .idx(bus.in_rs1_idx),
        .cur_data(bus.in_a_is_pc ? bus.in_pc : bus.in_rs1_data),
        .ex_valid(bus.ex_byp_valid), .ex_idx(bus.ex_byp_idx), .ex_data(bus.ex_byp_data),
        .wb_valid(bus.wb_byp_valid), .wb_idx(bus.wb_byp_idx), .wb_data(bus.wb_byp_data),
        .data_out(cap_op.a), .byp_out(cap_op.a_byp)
    );

    alu_byp_mux u_cap_b (
        .src_is_reg(!bus.in_b_is_imm), .idx(bus.in_rs2_idx),
        .cur_data(bus.in_b_is_imm ? bus.in_imm : bus.in_rs2_data),
        .ex_valid(bus.ex_byp_valid), .ex_idx(bus.ex_byp_idx), .ex_data(bus.ex_byp_data),
        .wb_valid(bus.wb_byp_valid), .wb_idx(bus.wb_byp_idx), .wb_data(bus.wb_byp_data),
        .data_out(cap_op.b), .byp_out(cap_op.b_byp)
    );

    assign main_upd.fn    = main_q.fn;
    assign main_upd.a_idx = main_q.a_idx;
    assign main_upd.b_idx = main_q.b_idx;
    assign skid_upd.fn    = skid_q.fn;
    assign skid_upd.a_idx = skid_q.a_idx;
    assign skid_upd.b_idx = skid_q.b_idx;

    alu_byp_mux u_main_a (
        .src_is_reg(main_q.a_byp), .idx(main_q.a_idx), .cur_data(main_q.a),
        .ex_valid(bus.ex_byp_valid), .ex_idx(bus.ex_byp_idx), .ex_data(bus.ex_byp_data),
        .wb_valid(bus.wb_byp_valid), .wb_idx(bus.wb_byp_idx), .wb_data(bus.wb_byp_data),
        .data_out(main_upd.a), .byp_out(main_upd.a_byp)
    );

    alu_byp_mux u_main_b (
        .src_is_reg(main_q.b_byp), .idx(main_q.b_idx), .cur_data(main_q.b),
        .ex_valid(bus.ex_byp_valid), .ex_idx(bus.ex_byp_idx), .ex_data(bus.ex_byp_data),
        .wb_valid(bus.wb_byp_valid), .wb_idx(bus.wb_byp_idx), .wb_data(bus.wb_byp_data),
        .data_out(main_upd.b), .byp_out(main_upd.b_byp)
    );

    alu_byp_mux u_skid_a (
        .src_is_reg(skid_q.a_byp), .idx(skid_q.a_idx), .cur_data(skid_q.a),
        .ex_valid(bus.ex_byp_valid), .ex_idx(bus.ex_byp_idx), .ex_data(bus.ex_byp_data),
        .wb_valid(bus.wb_byp_valid), .wb_idx(bus.wb_byp_idx), .wb_data(bus.wb_byp_data),
        .data_out(skid_upd.a), .byp_out(skid_upd.a_byp)
    );

    alu_byp_mux u_skid_b (
        .src_is_reg(skid_q.b_byp), .idx(skid_q.b_idx), .cur_data(skid_q.b),
        .ex_valid(bus.ex_byp_valid), .ex_idx(bus.ex_byp_idx), .ex_data(bus.ex_byp_data),
        .wb_valid(bus.wb_byp_valid), .wb_idx(bus.wb_byp_idx), .wb_data(bus.wb_byp_data),
        .data_out(skid_upd.b), .byp_out(skid_upd.b_byp)
    );

    // Held entries always take the bypassed view, so a stalled op keeps snooping results.
    always_comb begin
        state_d = state_q;
        main_d  = main_q;
        skid_d  = skid_q;
        case (state_q)
            ST_EMPTY: begin
                if (in_fire) begin
                    main_d  = cap_op;
                    state_d = ST_ONE;
                end
            end
            ST_ONE: begin
                main_d = main_upd;
                if (in_fire && out_fire) begin
                    main_d = cap_op;
                end else if (in_fire) begin
                    skid_d  = cap_op;
                    state_d = ST_FULL;
                end else if (out_fire) begin
                    state_d = ST_EMPTY;
                end
            end
            ST_FULL: begin
                if (out_fire) begin
                    main_d  = skid_upd;
                    state_d = ST_ONE;
                end else begin
                    main_d = main_upd;
                    skid_d = skid_upd;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
        in_ready_d = (state_d != ST_FULL);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= ST_EMPTY;
            in_ready_q <= 1'b1;
            main_q     <= '0;
            skid_q     <= '0;
        end else begin
            state_q    <= state_d;
            in_ready_q <= in_ready_d;
            main_q     <= main_d;
            skid_q     <= skid_d;
        end
    end

`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0] stall_cnt_q, stall_cnt_d;

    always_comb begin
        stall_cnt_d = stall_cnt_q;
        if (main_valid && !bus.out_ready) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            stall_cnt_q <= '0;
        end else begin
            stall_cnt_q <= stall_cnt_d;
        end
    end

    assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_alu_operand_stage.sv
// Scoreboard bench for alu_operand_stage; define ALU_OPSTAGE_PERF_EN to also cover stall_cnt.
module tb_alu_operand_stage;
    import alu_pkg::*;

    typedef struct packed {
        logic [4:0]  fn;
        logic [31:0] a;
        logic [31:0] b;
    } exp_t;

    logic clock = 1'b0;
    logic reset;
    int   tests_run    = 0;
    int   tests_failed = 0;
    exp_t sb[$];

    alu_operand_stage_if bus ();

`ifdef ALU_OPSTAGE_PERF_EN
    logic [31:0] stall_cnt;
    alu_operand_stage dut (.clock(clock), .reset(reset), .bus(bus), .stall_cnt(stall_cnt));
`else
    alu_operand_stage dut (.clock(clock), .reset(reset), .bus(bus));
`endif

    always #5 clock = ~clock;

    // Every accepted output is popped from the scoreboard on the falling edge before it fires.
    always @(negedge clock) begin
        if (!reset && bus.out_valid && bus.out_ready) begin
            tests_run++;
            if (sb.size() == 0) begin
                tests_failed++;
                $display("[TB] FAIL stale_op got fn=%h a=%h b=%h with nothing expected",
                         bus.out_fn, bus.out_a, bus.out_b);
            end else begin
                exp_t e;
                e = sb.pop_front();
                if (bus.out_fn !== e.fn || bus.out_a !== e.a || bus.out_b !== e.b) begin
                    tests_failed++;
                    $display("[TB] FAIL scoreboard got fn=%h a=%h b=%h exp fn=%h a=%h b=%h",
                             bus.out_fn, bus.out_a, bus.out_b, e.fn, e.a, e.b);
                end
            end
        end
    end

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic drive_op(input logic [4:0] fn,
                            input logic [4:0] rs1_idx, input logic [31:0] rs1_data,
                            input logic [4:0] rs2_idx, input logic [31:0] rs2_data,
                            input logic a_is_pc, input logic [31:0] pc,
                            input logic b_is_imm, input logic [31:0] imm);
        bus.in_valid    = 1'b1;
        bus.in_fn       = fn;
        bus.in_rs1_idx  = rs1_idx;
        bus.in_rs1_data = rs1_data;
        bus.in_rs2_idx  = rs2_idx;
        bus.in_rs2_data = rs2_data;
        bus.in_a_is_pc  = a_is_pc;
        bus.in_pc       = pc;
        bus.in_b_is_imm = b_is_imm;
        bus.in_imm      = imm;
    endtask

    task automatic set_byp(input logic exv, input logic [4:0] exi, input logic [31:0] exd,
                           input logic wbv, input logic [4:0] wbi, input logic [31:0] wbd);
        bus.ex_byp_valid = exv;
        bus.ex_byp_idx   = exi;
        bus.ex_byp_data  = exd;
        bus.wb_byp_valid = wbv;
        bus.wb_byp_idx   = wbi;
        bus.wb_byp_data  = wbd;
    endtask

    function automatic logic [31:0] model_src(input logic is_reg, input logic [4:0] idx,
                                              input logic [31:0] data);
        if (!is_reg) return data;
        if (idx == 5'd0) return 32'h0;
        if (bus.ex_byp_valid && bus.ex_byp_idx == idx) return bus.ex_byp_data;
        if (bus.wb_byp_valid && bus.wb_byp_idx == idx) return bus.wb_byp_data;
        return data;
    endfunction

    task automatic test_drain(input string name);
        tests_run++;
        if (sb.size() != 0) begin
            tests_failed++;
            $display("[TB] FAIL %s_drain got %0d pending ops exp 0", name, sb.size());
        end
        sb.delete();
    endtask

    task automatic test_reset();
        bus.in_valid = 1'b0;
        bus.out_ready = 1'b0;
        drive_op(5'h0, 5'h0, 32'h0, 5'h0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
        bus.in_valid = 1'b0;
        set_byp(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
        reset = 1'b1;
        step();
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_out_valid got %b exp 0", bus.out_valid);
        end
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL reset_in_ready got %b exp 1", bus.in_ready);
        end
        tests_run++;
        if (bus.out_fn !== 5'h0 || bus.out_a !== 32'h0 || bus.out_b !== 32'h0) begin
            tests_failed++;
            $display("[TB] FAIL reset_outputs got fn=%h a=%h b=%h exp 0", bus.out_fn, bus.out_a, bus.out_b);
        end
`ifdef ALU_OPSTAGE_PERF_EN
        tests_run++;
        if (stall_cnt !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL reset_stall_cnt got %h exp 0", stall_cnt);
        end
`endif
        reset = 1'b0;
        step();
    endtask

    task automatic test_basic();
        bus.out_ready = 1'b1;
        drive_op(FN_ADD, 5'd3, 32'h10, 5'd4, 32'h20, 1'b0, 32'h0, 1'b0, 32'h0);
        sb.push_back('{FN_ADD, 32'h10, 32'h20});
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL basic_latency got out_valid=%b exp 1", bus.out_valid);
        end
        step();
        step();
        test_drain("basic");
    endtask

    task automatic test_capture_bypass();
        bus.out_ready = 1'b1;
        set_byp(1'b1, 5'd5, 32'hAAAA, 1'b1, 5'd5, 32'hBBBB);
        drive_op(FN_ADD, 5'd5, 32'h11, 5'd6, 32'h66, 1'b0, 32'h0, 1'b0, 32'h0);
        sb.push_back('{FN_ADD, 32'hAAAA, 32'h66});
        step();
        drive_op(FN_SUB, 5'd0, 32'h1234, 5'd5, 32'h55, 1'b0, 32'h0, 1'b0, 32'h0);
        sb.push_back('{FN_SUB, 32'h0, 32'hAAAA});
        step();
        set_byp(1'b0, 5'd5, 32'hAAAA, 1'b1, 5'd6, 32'hBBBB);
        drive_op(FN_XOR, 5'd5, 32'h77, 5'd6, 32'h88, 1'b0, 32'h0, 1'b0, 32'h0);
        sb.push_back('{FN_XOR, 32'h77, 32'hBBBB});
        step();
        bus.in_valid = 1'b0;
        set_byp(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
        step();
        step();
        test_drain("capture_bypass");
    endtask

    task automatic test_stall_snoop();
        bus.out_ready = 1'b0;
        drive_op(5'h3, 5'd7, 32'h70, 5'd9, 32'h90, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b1 || bus.out_b !== 32'h90) begin
            tests_failed++;
            $display("[TB] FAIL snoop_before got valid=%b b=%h exp 1 00000090", bus.out_valid, bus.out_b);
        end
        set_byp(1'b0, 5'h0, 32'h0, 1'b1, 5'd9, 32'h1234);
        step();
        set_byp(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
        tests_run++;
        if (bus.out_b !== 32'h1234) begin
            tests_failed++; $display("[TB] FAIL snoop_update got b=%h exp 00001234", bus.out_b);
        end
        step();
        tests_run++;
        if (bus.out_b !== 32'h1234 || bus.out_a !== 32'h70 || bus.out_fn !== 5'h3) begin
            tests_failed++;
            $display("[TB] FAIL snoop_hold got fn=%h a=%h b=%h exp 03 00000070 00001234",
                     bus.out_fn, bus.out_a, bus.out_b);
        end
        sb.push_back('{5'h3, 32'h70, 32'h1234});
        bus.out_ready = 1'b1;
        step();
        step();
        test_drain("stall_snoop");
    endtask

    task automatic test_skid();
        bus.out_ready = 1'b0;
        drive_op(FN_OR, 5'd1, 32'hA1, 5'd2, 32'hB1, 1'b0, 32'h0, 1'b0, 32'h0);
        sb.push_back('{FN_OR, 32'hA1, 32'hB1});
        step();
        drive_op(FN_XOR, 5'd3, 32'hA2, 5'd4, 32'hB2, 1'b0, 32'h0, 1'b0, 32'h0);
        sb.push_back('{FN_XOR, 32'hA2, 32'hB2});
        step();
        drive_op(FN_SLL, 5'd5, 32'hA3, 5'd6, 32'hB3, 1'b0, 32'h0, 1'b0, 32'h0);
        tests_run++;
        if (bus.in_ready !== 1'b0 || bus.out_a !== 32'hA1) begin
            tests_failed++;
            $display("[TB] FAIL skid_full got in_ready=%b a=%h exp 0 000000a1", bus.in_ready, bus.out_a);
        end
        step();
        tests_run++;
        if (bus.in_ready !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL skid_hold got in_ready=%b exp 0", bus.in_ready);
        end
        bus.out_ready = 1'b1;
        step();
        tests_run++;
        if (bus.in_ready !== 1'b1) begin
            tests_failed++; $display("[TB] FAIL skid_release got in_ready=%b exp 1", bus.in_ready);
        end
        sb.push_back('{FN_SLL, 32'hA3, 32'hB3});
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        test_drain("skid");
    endtask

    task automatic test_imm_pc();
        bus.out_ready = 1'b0;
        set_byp(1'b1, 5'd2, 32'hDEAD_BEEF, 1'b1, 5'd3, 32'hCAFE_F00D);
        drive_op(FN_ADD, 5'd2, 32'h1111, 5'd3, 32'h2222, 1'b1, 32'h8000_0100, 1'b1, 32'hFFFF_FFFC);
        step();
        bus.in_valid = 1'b0;
        tests_run++;
        if (bus.out_a !== 32'h8000_0100 || bus.out_b !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("[TB] FAIL imm_pc_capture got a=%h b=%h exp 80000100 fffffffc", bus.out_a, bus.out_b);
        end
        step();
        tests_run++;
        if (bus.out_a !== 32'h8000_0100 || bus.out_b !== 32'hFFFF_FFFC) begin
            tests_failed++;
            $display("[TB] FAIL imm_pc_held got a=%h b=%h exp 80000100 fffffffc", bus.out_a, bus.out_b);
        end
        sb.push_back('{FN_ADD, 32'h8000_0100, 32'hFFFF_FFFC});
        bus.out_ready = 1'b1;
        step();
        set_byp(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
        step();
        test_drain("imm_pc");
    endtask

    task automatic test_back_to_back();
        bus.out_ready = 1'b1;
        for (int i = 0; i < 8; i++) begin
            logic [4:0]  i1, i2;
            logic [31:0] d1, d2, pc, imm;
            logic        apc, bimm;
            set_byp(1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom(),
                    1'($urandom_range(0, 1)), 5'($urandom_range(0, 3)), $urandom());
            i1 = 5'($urandom_range(0, 3));
            i2 = 5'($urandom_range(0, 3));
            d1 = $urandom();
            d2 = $urandom();
            pc = $urandom();
            imm = $urandom();
            apc = 1'($urandom_range(0, 1));
            bimm = 1'($urandom_range(0, 1));
            drive_op(5'(i), i1, d1, i2, d2, apc, pc, bimm, imm);
            sb.push_back('{5'(i), model_src(!apc, i1, apc ? pc : d1), model_src(!bimm, i2, bimm ? imm : d2)});
            tests_run++;
            if (bus.in_ready !== 1'b1) begin
                tests_failed++; $display("[TB] FAIL b2b_in_ready op %0d got %b exp 1", i, bus.in_ready);
            end
            step();
        end
        bus.in_valid = 1'b0;
        set_byp(1'b0, 5'h0, 32'h0, 1'b0, 5'h0, 32'h0);
        step();
        step();
        test_drain("back_to_back");
    endtask

    task automatic test_reset_mid();
        bus.out_ready = 1'b0;
        drive_op(FN_AND, 5'd1, 32'h1, 5'd2, 32'h2, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        drive_op(FN_AND, 5'd3, 32'h3, 5'd4, 32'h4, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        bus.in_valid = 1'b0;
        reset = 1'b1;
        step();
        reset = 1'b0;
        tests_run++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            tests_failed++;
            $display("[TB] FAIL reset_mid got out_valid=%b in_ready=%b exp 0 1", bus.out_valid, bus.in_ready);
        end
`ifdef ALU_OPSTAGE_PERF_EN
        tests_run++;
        if (stall_cnt !== 32'h0) begin
            tests_failed++; $display("[TB] FAIL reset_mid_stall_cnt got %h exp 0", stall_cnt);
        end
`endif
        bus.out_ready = 1'b1;
        step();
        step();
        step();
        tests_run++;
        if (bus.out_valid !== 1'b0) begin
            tests_failed++; $display("[TB] FAIL reset_mid_after got out_valid=%b exp 0", bus.out_valid);
        end
        test_drain("reset_mid");
    endtask

`ifdef ALU_OPSTAGE_PERF_EN
    task automatic test_perf();
        bus.out_ready = 1'b0;
        drive_op(FN_ADD, 5'd8, 32'h80, 5'd9, 32'h90, 1'b0, 32'h0, 1'b0, 32'h0);
        step();
        bus.in_valid = 1'b0;
        step();
        step();
        step();
        tests_run++;
        if (stall_cnt !== 32'd3) begin
            tests_failed++; $display("[TB] FAIL perf_count got %0d exp 3", stall_cnt);
        end
        sb.push_back('{FN_ADD, 32'h80, 32'h90});
        bus.out_ready = 1'b1;
        step();
        tests_run++;
        if (stall_cnt !== 32'd3) begin
            tests_failed++; $display("[TB] FAIL perf_no_count_on_fire got %0d exp 3", stall_cnt);
        end
        step();
        test_drain("perf");
    endtask
`endif

    initial begin
        test_reset();
        test_basic();
        test_capture_bypass();
        test_stall_snoop();
        test_skid();
        test_imm_pc();
        test_back_to_back();
        test_reset_mid();
`ifdef ALU_OPSTAGE_PERF_EN
        test_perf();
`endif
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule

// File: doc/alu_operand_stage.md
Name: alu_operand_stage

Overview:
- Pipeline register stage directly upstream of the 32-bit integer ALU.
- Captures decoded ops from decode: 5-bit function code, register-file operands, immediate, PC.
- Selects the ALU A/B operands and applies EX/WB result bypass, both at capture and while an op is held stalled.
- 2-entry skid buffer gives a fully registered valid/ready on both sides, with no combinational ready path from downstream to upstream.

Parameters:
- XLEN, 32, operand/result width; the ALU is fixed at 32, other values unsupported.
- FN_W, 5, ALU function code width.

Ports:
- clock  in  1  single clock, rising edge.
- reset  in  1  synchronous, active-high.
- in_valid  in  1  decode presents an op.
- in_ready  out  1  stage can accept; registered.
- in_fn  in  5  ALU function code, passed through unchanged.
- in_rs1_idx  in  5  rs1 architectural index.
- in_rs2_idx  in  5  rs2 architectural index.
- in_rs1_data  in  32  register-file read of rs1.
- in_rs2_data  in  32  register-file read of rs2.
- in_imm  in  32  sign-extended immediate.
- in_pc  in  32  PC of the op.
- in_a_is_pc  in  1  A operand = in_pc instead of rs1.
- in_b_is_imm  in  1  B operand = in_imm instead of rs2.
- ex_byp_valid  in  1  EX result bypass valid.
- ex_byp_idx  in  5  EX destination index.
- ex_byp_data  in  32  EX result.
- wb_byp_valid  in  1  WB result bypass valid.
- wb_byp_idx  in  5  WB destination index.
- wb_byp_data  in  32  WB result.
- out_valid  out  1  op presented to the ALU.
- out_ready  in  1  ALU/EX accepts.
- out_fn  out  5  to ALU function input.
- out_a  out  32  ALU first operand.
- out_b  out  32  ALU second operand.

Behaviour:
- Reset: out_valid=0, in_ready=1, out_fn=5'h0, out_a=0, out_b=0, both entries invalid, perf counter=0. Reset mid-transfer drops all held ops, and no handshake completes in the reset cycle.
- Transfer rules: in fires on in_valid&in_ready; out fires on out_valid&out_ready. in_valid must not depend on in_ready.
- Storage: a main entry (drives the outputs) and a skid entry. Each holds fn, a, b, a_idx, b_idx, a_byp, b_byp.
  - a_byp=0 when in_a_is_pc or rs1_idx==0.
  - b_byp=0 when in_b_is_imm or rs2_idx==0.
- Capture:
  - a = pc if a_is_pc, else rs1_data.
  - b = imm if b_is_imm, else rs2_data.
  - Bypass is applied at capture (same-cycle forwarding).
  - Index 0 always yields 32'h0 for register sources, regardless of rs*_data or bypass.
- Bypass, evaluated every cycle for every valid entry:
  - If the byp flag is set and ex_byp_valid and ex_byp_idx==idx, the operand gets ex_byp_data.
  - Else if the byp flag is set and wb_byp_valid and wb_byp_idx==idx, the operand gets wb_byp_data.
  - EX has priority over WB. Updates to held entries land at the next edge.
- States: EMPTY, ONE (main valid), FULL (main+skid valid).
  - EMPTY, in fire → ONE.
  - ONE, in fire without out fire → FULL (new op to skid).
  - ONE, in fire with out fire → ONE (new op to main).
  - ONE, out fire only → EMPTY.
  - FULL, out fire → ONE (skid moves to main, with bypass applied).
  - FULL, no out fire → FULL.
- in_ready is registered: 1 in EMPTY/ONE, 0 in FULL. It is 1 in the cycle after FULL→ONE.
- out_valid = main valid. Outputs are stable while out_valid&!out_ready, except that bypass updates of operands are permitted.
- Latency: in fire at cycle N → out_valid at N+1. Sustained throughput is 1 op/cycle with out_ready=1.
- No arithmetic is performed here. Widths are exact and there is no truncation.

Optional Feature:
- Macro ALU_OPSTAGE_PERF_EN.
- Defined:
  - Adds output stall_cnt [31:0].
  - Increments when out_valid&!out_ready; wraps 32'hFFFFFFFF→0.
  - Clears on reset.
- Undefined: port and counter are absent; behaviour is otherwise identical.

Decomposition:
- Package alu_pkg holds:
  - XLEN and FN_W.
  - ALU function constants, including FN_ADD=5'h8.
  - A struct alu_op_t {fn, a, b, a_idx, b_idx, a_byp, b_byp}.
- Sub-module alu_byp_mux: per-operand EX/WB priority compare/select with x0 guard. It is instantiated 4× (2 entries × 2 operands) plus 2× at capture.

Test Plan:
- Basic: rs1=3 data 0x10, rs2=4 data 0x20, fn 5'h8, out_ready=1 → next cycle out_a=0x10, out_b=0x20, out_fn=5'h8, out_valid=1.
- Capture bypass: rs1_idx=5, ex_byp_idx=5 data 0xAAAA, wb_byp_idx=5 data 0xBBBB both valid → out_a=0xAAAA (EX priority). rs1_idx=0 with the same bypass → out_a=0.
- Stall snoop: hold out_ready=0, then WB bypass idx=rs2 data 0x1234 for one cycle → out_b becomes 0x1234 next cycle and stays until out fires.
- Skid: out_ready=0, 2 ops in → in_ready=0 in FULL. Release out_ready → ops emerge in order with no loss, and in_ready=1 the following cycle.
- Immediate/PC: a_is_pc=1 pc 0x8000_0100, b_is_imm=1 imm 0xFFFF_FFFC, EX bypass matching rs1/rs2 → out_a=0x8000_0100, out_b=0xFFFF_FFFC (no bypass).
- Reset mid-operation: FULL, assert reset one cycle → out_valid=0, in_ready=1, stall_cnt=0 (if PERF_EN), and no stale op emerges afterward.
